ham_secded_pipe: RTL

Parametrised, pipelined Hamming decoder: the successor of the fixed (7,4) syndrome/correct stage. Accepts one codeword per cycle on a valid/ready stream, computes the syndrome, corrects single-bit errors, and emits the data bits with error status two cycles later. Saturating error counters give the display/debug logic a running health view of the link. Optionally extended to SECDED (single-error correct, double-error detect) via an overall parity bit.

---
 rtl/ham_secded_pipe.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/ham_secded_pipe.sv
// Two-stage pipelined Hamming decoder with saturating corrected/uncorrectable counters.
// Define HAM_SECDED_EN to use the overall parity bit for double-error detection.
module ham_secded_pipe #(
  parameter int unsigned PAR_W  = 3,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned CODE_W = (1 << PAR_W) - 1,
  localparam int unsigned DATA_W = CODE_W - PAR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W:0]   in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PAR_W-1:0]  out_syndrome,
  output logic              out_corr,
  output logic              out_uncorr,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  // Position (1-based) of the j-th data bit: the j-th non-power-of-two index.
  function automatic int unsigned data_pos(input int unsigned j);
    int unsigned cnt;
    int unsigned pos;
    cnt = 0;
    pos = 0;
    for (int unsigned p = 1; p <= CODE_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == j) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

  logic                s1_valid_q, s1_valid_d;
  logic [CODE_W-1:0]   s1_code_q;
  logic [PAR_W-1:0]    s1_syn_q, syn_d;
  logic                s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0]   s2_data_q, data_d;
  logic [PAR_W-1:0]    s2_syn_q;
  logic                s2_corr_q, corr_d;
  logic                s2_uncorr_q, uncorr_d;
  logic [CNT_W-1:0]    corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0]    uncorr_cnt_q, uncorr_cnt_d;
  logic                s2_load, s1_adv, in_acc, out_hs;
  logic                flip;
  logic [CODE_W-1:0]   fixed;

`ifdef HAM_SECDED_EN
  logic s1_par_q;
`else
  logic ovp_unused;
  assign ovp_unused = in_code[CODE_W];
`endif

  always_comb begin
    syn_d = '0;
    for (int unsigned k = 1; k <= CODE_W; k++) begin
      for (int unsigned i = 0; i < PAR_W; i++) begin
        if (k[i]) syn_d[i] = syn_d[i] ^ in_code[k-1];
      end
    end
  end

  always_comb begin
`ifdef HAM_SECDED_EN
    flip     = (|s1_syn_q) && s1_par_q;
    corr_d   = s1_par_q;
    uncorr_d = (|s1_syn_q) && !s1_par_q;
`else
    flip     = |s1_syn_q;
    corr_d   = |s1_syn_q;
    uncorr_d = 1'b0;
`endif
    fixed = s1_code_q;
    for (int unsigned k = 1; k <= CODE_W; k++) begin
      if (flip && (s1_syn_q == PAR_W'(k))) fixed[k-1] = ~fixed[k-1];
    end
    data_d = '0;
    for (int unsigned j = 0; j < DATA_W; j++) begin
      for (int unsigned k = 1; k <= CODE_W; k++) begin
        if (data_pos(j) == k) data_d[j] = fixed[k-1];
      end
    end
  end

  always_comb begin
    s2_load    = !s2_valid_q || out_ready;
    s1_adv     = s1_valid_q && s2_load;
    in_ready   = !s1_valid_q || s1_adv;
    in_acc     = in_valid && in_ready;
    out_hs     = s2_valid_q && out_ready;
    s1_valid_d = in_ready ? in_valid : s1_valid_q;
    s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;

    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    // Clear wins over a same-cycle increment.
    if (cnt_clr) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else if (out_hs) begin
      if (s2_corr_q && (corr_cnt_q != '1))     corr_cnt_d   = corr_cnt_q + CNT_W'(1);
      if (s2_uncorr_q && (uncorr_cnt_q != '1)) uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_code_q    <= '0;
      s1_syn_q     <= '0;
`ifdef HAM_SECDED_EN
      s1_par_q     <= 1'b0;
`endif
      s2_valid_q   <= 1'b0;
      s2_data_q    <= '0;
      s2_syn_q     <= '0;
      s2_corr_q    <= 1'b0;
      s2_uncorr_q  <= 1'b0;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s2_valid_q   <= s2_valid_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
      if (in_acc) begin
        s1_code_q <= in_code[CODE_W-1:0];
        s1_syn_q  <= syn_d;
`ifdef HAM_SECDED_EN
        s1_par_q  <= ^in_code;
`endif
      end
      if (s1_adv) begin
        s2_data_q   <= data_d;
        s2_syn_q    <= s1_syn_q;
        s2_corr_q   <= corr_d;
        s2_uncorr_q <= uncorr_d;
      end
    end
  end

  assign out_valid    = s2_valid_q;
  assign out_data     = s2_data_q;
  assign out_syndrome = s2_syn_q;
  assign out_corr     = s2_corr_q;
  assign out_uncorr   = s2_uncorr_q;
  assign corr_cnt     = corr_cnt_q;
  assign uncorr_cnt   = uncorr_cnt_q;

endmodule
